// File: rtl/tff_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module      : tff_sched_pkg
// Description : Shared types and helpers for the toggle-bank scheduler.
//               req_width() sizes requester indices. rr_pick() performs the
//               round-robin search over an eligibility vector.
// Revision    : 1.0 - initial release
// ============================================================================
package tff_sched_pkg;

    // Upper bound on requesters supported by rr_pick (eligibility is padded
    // to this width so the function has a fixed signature).
    localparam int MAX_NREQ = 32;

    // Result of a round-robin search.
    typedef struct packed {
        logic        found;
        logic [31:0] idx;
    } pick_t;

    // Width of an index into NREQ requesters. It is never narrower than 1 bit.
    function automatic int req_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // First set bit of elig, searching ptr, ptr+1, ... and wrapping at nreq.
    // ptr is always < nreq, so a single subtraction implements the wrap.
    function automatic pick_t rr_pick(input logic [MAX_NREQ-1:0] elig,
                                      input int                  nreq,
                                      input int                  ptr);
        pick_t r;
        int    idx;
        r = '0;
        for (int k = 0; k < MAX_NREQ; k++) begin
            if ((k < nreq) && !r.found) begin
                idx = ptr + k;
                if (idx >= nreq) begin
                    idx = idx - nreq;
                end
                if (elig[idx]) begin
                    r.found = 1'b1;
                    r.idx   = idx;
                end
            end
        end
        return r;
    endfunction

endpackage : tff_sched_pkg
`default_nettype wire

// File: rtl/tff_cell.sv
`default_nettype none
// ============================================================================
// Module      : tff_cell
// Description : One toggle flip-flop. The synchronous clear takes priority
//               over the toggle input.
// Ports       : clk   - rising-edge clock
//               reset - asynchronous active-high reset (q -> 0)
//               clr   - synchronous clear (q -> 0)
//               t     - toggle enable
//               q     - flop state
// Revision    : 1.0 - initial release
// ============================================================================
module tff_cell (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic t,
    output logic q
);

    logic q_d;
    logic q_q;

    always_comb begin
        q_d = q_q ^ t;
        if (clr) begin
            q_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q_q <= 1'b0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule : tff_cell
`default_nettype wire

// File: rtl/tff_toggle_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tff_toggle_scheduler
// Description : WIDTH-bit bank of toggle flops shared between NREQ
//               requesters through a round-robin arbiter. At most one grant
//               is made per cycle. The granted requester's mask drives the
//               T inputs of the bank.
// Ports       : clk       - rising-edge clock
//               reset     - asynchronous active-high reset
//               en        - arbitration enable (0 freezes grants)
//               clr       - synchronous clear of the bank; blocks grants
//               req       - per-requester toggle request
//               mask      - per-requester toggle masks, WIDTH bits each
//               ack       - one-cycle pulse, one-hot on the granted requester
//               gnt_valid - one-cycle pulse, a grant was applied last edge
//               grant_id  - index of the last granted requester (holds)
//               q         - toggle-bank state
//               grant_cnt - grants since reset, wraps silently
// Revision    : 1.0 - initial release
// ============================================================================
module tff_toggle_scheduler
    import tff_sched_pkg::*;
#(
    parameter  int NREQ  = 4,
    parameter  int WIDTH = 8,
    parameter  int CNT_W = 16,
    localparam int REQ_W = req_width(NREQ)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    en,
    input  logic                    clr,
    input  logic [NREQ-1:0]         req,
    input  logic [NREQ*WIDTH-1:0]   mask,
    output logic [NREQ-1:0]         ack,
    output logic                    gnt_valid,
    output logic [REQ_W-1:0]        grant_id,
    output logic [WIDTH-1:0]        q,
    output logic [CNT_W-1:0]        grant_cnt
);

    // ------------------------------------------------------------------
    // Registered state
    // ------------------------------------------------------------------
    logic [NREQ-1:0]  ack_q,       ack_d;
    logic             gnt_valid_q, gnt_valid_d;
    logic [REQ_W-1:0] grant_id_q,  grant_id_d;
    logic [REQ_W-1:0] rr_ptr_q,    rr_ptr_d;
    logic [CNT_W-1:0] grant_cnt_q, grant_cnt_d;

    // ------------------------------------------------------------------
    // Arbitration
    // ------------------------------------------------------------------
    logic [MAX_NREQ-1:0] elig_pad;
    pick_t               pick;
    logic [REQ_W-1:0]    win;
    logic                do_grant;
    logic [WIDTH-1:0]    win_mask;
    logic [WIDTH-1:0]    t_vec;

    always_comb begin
        // A requester acked this cycle is masked. A held req therefore
        // cannot win on two consecutive edges.
        elig_pad             = '0;
        elig_pad[NREQ-1:0]   = req & ~ack_q;

        pick     = rr_pick(elig_pad, NREQ, int'(rr_ptr_q));
        win      = REQ_W'(pick.idx);

        // The clear owns the cycle: no grant is made and requests stay pending.
        do_grant = en & ~clr & pick.found;

        // The mask is sampled only when its owner actually wins.
        win_mask = mask[win*WIDTH +: WIDTH];
        t_vec    = do_grant ? win_mask : '0;

        ack_d       = '0;
        gnt_valid_d = 1'b0;
        grant_id_d  = grant_id_q;
        rr_ptr_d    = rr_ptr_q;
        grant_cnt_d = grant_cnt_q;

        if (do_grant) begin
            ack_d[win]  = 1'b1;
            gnt_valid_d = 1'b1;
            grant_id_d  = win;
            rr_ptr_d    = (win == REQ_W'(NREQ - 1)) ? '0 : win + REQ_W'(1);
            grant_cnt_d = grant_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ack_q       <= '0;
            gnt_valid_q <= 1'b0;
            grant_id_q  <= '0;
            rr_ptr_q    <= '0;
            grant_cnt_q <= '0;
        end else begin
            ack_q       <= ack_d;
            gnt_valid_q <= gnt_valid_d;
            grant_id_q  <= grant_id_d;
            rr_ptr_q    <= rr_ptr_d;
            grant_cnt_q <= grant_cnt_d;
        end
    end

    // ------------------------------------------------------------------
    // Toggle bank
    // ------------------------------------------------------------------
    for (genvar b = 0; b < WIDTH; b++) begin : g_bank
        tff_cell u_cell (
            .clk   (clk),
            .reset (reset),
            .clr   (clr),
            .t     (t_vec[b]),
            .q     (q[b])
        );
    end

    assign ack       = ack_q;
    assign gnt_valid = gnt_valid_q;
    assign grant_id  = grant_id_q;
    assign grant_cnt = grant_cnt_q;

endmodule : tff_toggle_scheduler
`default_nettype wire
